aux_input_cond: RTL and testbench
=================================

Name: aux_input_cond

Overview:
- Input-side conditioner for the board I/O: slide switches and a push button in, clean synchronous control values out.
- Sits between the raw board pins and the core/top logic: switch mux selects, the resume button, and the debug register/address selects.
- Provides 2-flop synchronization, per-bit switch debounce, a switch-change strobe, and a debounced single-cycle button press pulse.

Parameters:
- SwtBits, 16, number of slide switch inputs.
- DebounceCnt, 1000000, consecutive stable clk cycles required to accept a new level (10 ms at 100 MHz); legal range >= 2.
- RepeatCnt, 50000000, hold cycles between auto-repeat pulses (used only with the optional feature); legal range >= 2.

Ports:
- clk  in  1  board clock.
- rst_n  in  1  asynchronous active-low reset.
- swt_raw  in  SwtBits  raw slide switches, asynchronous to clk.
- btn_raw  in  1  raw push button, active-high, asynchronous to clk.
- swt  out  SwtBits  debounced switch levels.
- swt_chg  out  1  one-cycle strobe in the cycle any swt bit updates.
- btn_level  out  1  debounced button level.
- btn_pulse  out  1  one-cycle pulse per accepted press.

Behaviour:
- Reset: all flops are cleared asynchronously on rst_n low. This covers the synchronizers, stable registers, all counters, and the FSM (to IDLE). swt, swt_chg, btn_level and btn_pulse are all 0 during reset.
- Synchronizer: each raw bit passes through 2 flops before any other logic sees it. Raw inputs are never used directly.
- Per-bit switch debounce, one counter per bit:
  - If the synced bit equals the stable bit, the counter clears.
  - Otherwise the counter increments. When it reaches DebounceCnt-1, the stable bit takes the synced value and the counter clears in the same cycle.
  - Latency from a raw change to swt: 2 + DebounceCnt cycles.
  - A glitch shorter than DebounceCnt cycles produces no change.
- swt_chg: asserted for exactly one cycle, in the cycle after any swt bit updates. If several bits update in the same cycle, only one strobe is generated. Bits that update in consecutive cycles produce consecutive strobes.
- Counter width: $clog2 of the largest of DebounceCnt and RepeatCnt, plus 1. Counters saturate and never wrap.
- Button FSM states: IDLE, DEB_PRESS, HELD, DEB_REL.
  - IDLE: if synced is high, go to DEB_PRESS with the counter at 0.
  - DEB_PRESS: if synced is low, return to IDLE (no pulse). If the counter reaches DebounceCnt-1, go to HELD and drive btn_pulse=1 for that one transition cycle.
  - HELD: if synced is low, go to DEB_REL with the counter at 0.
  - DEB_REL: if synced is high, return to HELD (no pulse). If the counter reaches DebounceCnt-1, go to IDLE.
  - btn_level is 1 in HELD and DEB_REL, and 0 otherwise.
- Press-pulse latency: btn_pulse rises 2 + DebounceCnt cycles after the btn_raw rising edge.
- Bounce during release never produces a second pulse.
- Reset mid-operation: the FSM returns to IDLE and the counters clear.
  - A button still held when rst_n deasserts is treated as a new press. It is debounced and produces exactly one btn_pulse.
  - Switch bits already high after reset produce a swt update and a swt_chg strobe after the debounce delay.

Optional Feature:
- Macro: AUX_INPUT_COND_AUTOREPEAT_EN.
- Defined: while the FSM is in HELD, a repeat counter runs. It increments each cycle and emits btn_pulse when it reaches RepeatCnt-1, then clears. The counter clears on entry to HELD and in any other state.
- Leaving HELD, including the DEB_REL → HELD bounce path, restarts the repeat count from 0.
- Not defined: no repeat counter is instantiated, and exactly one pulse is generated per press.

Test Plan:
- Parameters: DebounceCnt=8, RepeatCnt=20 in all scenarios.
- Reset check: hold rst_n low with swt_raw=16'hFFFF and btn_raw=1 → all outputs stay 0 for the whole reset.
- Clean switch edge: swt_raw bit3 goes 0→1 → swt=16'h0008 exactly 10 cycles later, with swt_chg high for the following 1 cycle only.
- Switch glitch: bit5 high for 5 cycles, then low → swt unchanged and swt_chg never asserted.
- Press with bounce: btn_raw toggles 4 times at 2-cycle intervals, then holds high for 30 cycles → exactly one btn_pulse, 10 cycles after the final rising edge. btn_level=1.
- Release with bounce: 3-cycle low glitches while held, then a clean release → no extra pulse. btn_level falls 10 cycles after the last falling edge.
- Auto-repeat:
  - Macro defined: hold btn for 100 cycles after the first pulse → pulses every 20 cycles (5 repeats).
  - Macro undefined: same stimulus → no repeats.
- Reset mid-press: assert rst_n in DEB_PRESS, release rst_n with btn held → exactly one pulse 10 cycles after deassert.

Source files
------------

// File: rtl/aux_input_cond_if.sv
// aux_input_cond board-side bundle: raw pins in,
// conditioned control values out.
interface aux_input_cond_if #(
  parameter int SwtBits = 16
);
  logic [SwtBits-1:0] swt_raw;
  logic               btn_raw;
  logic [SwtBits-1:0] swt;
  logic               swt_chg;
  logic               btn_level;
  logic               btn_pulse;

  modport master (
    output swt_raw, btn_raw,
    input  swt, swt_chg, btn_level, btn_pulse
  );

  modport slave (
    input  swt_raw, btn_raw,
    output swt, swt_chg, btn_level, btn_pulse
  );
endinterface

// File: rtl/aux_input_cond.sv
// aux_input_cond: sync + debounce for switches/button.
// AUX_INPUT_COND_AUTOREPEAT_EN adds held-button repeat.
module aux_input_cond #(
  parameter int SwtBits     = 16,
  parameter int DebounceCnt = 1000000,
  parameter int RepeatCnt   = 50000000
) (
  input logic           clk,
  input logic           rst_n,
  aux_input_cond_if.slave io
);

  localparam int MaxCnt = (DebounceCnt > RepeatCnt) ?
                          DebounceCnt : RepeatCnt;
  localparam int CntW = $clog2(MaxCnt) + 1;

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t DebLast = cnt_t'(DebounceCnt - 1);
  localparam cnt_t CntMax  = '1;

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    DEB_REL
  } btn_st_e;

  function automatic cnt_t sat_inc(cnt_t c);
    return (c == CntMax) ? c : c + cnt_t'(1);
  endfunction

  logic [SwtBits-1:0] swt_s1_q, swt_s2_q;
  logic               btn_s1_q, btn_s2_q;

  cnt_t [SwtBits-1:0] swt_cnt_q, swt_cnt_d;
  logic [SwtBits-1:0] swt_q, swt_d;
  logic [SwtBits-1:0] upd;
  logic               upd_q, chg_q;

  btn_st_e state_q, state_d;
  cnt_t    bcnt_q, bcnt_d, bcnt_inc;
  logic    pulse_q, pulse_d;
  logic    rpt_pulse;

  // two-flop synchronizers on every raw pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swt_s1_q <= '0;
      swt_s2_q <= '0;
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
    end else begin
      swt_s1_q <= io.swt_raw;
      swt_s2_q <= swt_s1_q;
      btn_s1_q <= io.btn_raw;
      btn_s2_q <= btn_s1_q;
    end
  end

  // per-bit mismatch counters; accept after DebounceCnt samples
  always_comb begin
    swt_d     = swt_q;
    swt_cnt_d = '0;
    upd       = '0;
    for (int i = 0; i < SwtBits; i++) begin
      if (swt_s2_q[i] != swt_q[i]) begin
        if (swt_cnt_q[i] == DebLast) begin
          swt_d[i] = swt_s2_q[i];
          upd[i]   = 1'b1;
        end else begin
          swt_cnt_d[i] = sat_inc(swt_cnt_q[i]);
        end
      end
    end
  end

  // stable levels, counters and the delayed change strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swt_q     <= '0;
      swt_cnt_q <= '0;
      upd_q     <= 1'b0;
      chg_q     <= 1'b0;
    end else begin
      swt_q     <= swt_d;
      swt_cnt_q <= swt_cnt_d;
      upd_q     <= |upd;
      chg_q     <= upd_q;
    end
  end

  // button FSM; the entry sample plus DebounceCnt-1 counts
  // gives the same acceptance window as the switches
  always_comb begin
    state_d  = state_q;
    bcnt_d   = '0;
    pulse_d  = 1'b0;
    bcnt_inc = sat_inc(bcnt_q);
    case (state_q)
      IDLE: begin
        if (btn_s2_q) state_d = DEB_PRESS;
      end
      DEB_PRESS: begin
        if (!btn_s2_q) begin
          state_d = IDLE;
        end else if (bcnt_inc == DebLast) begin
          state_d = HELD;
          pulse_d = 1'b1;
        end else begin
          bcnt_d = bcnt_inc;
        end
      end
      HELD: begin
        if (!btn_s2_q) state_d = DEB_REL;
      end
      DEB_REL: begin
        if (btn_s2_q) begin
          state_d = HELD;
        end else if (bcnt_inc == DebLast) begin
          state_d = IDLE;
        end else begin
          bcnt_d = bcnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, shared debounce counter and registered pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      pulse_q <= pulse_d | rpt_pulse;
    end
  end

`ifdef AUX_INPUT_COND_AUTOREPEAT_EN
  localparam cnt_t RptLast = cnt_t'(RepeatCnt - 1);

  cnt_t rpt_q, rpt_d;
  logic rpt_hit;

  // repeat count runs only while staying in HELD
  always_comb begin
    rpt_d   = '0;
    rpt_hit = (state_q == HELD) && (rpt_q == RptLast);
    if (state_q == HELD && state_d == HELD && !rpt_hit)
      rpt_d = sat_inc(rpt_q);
  end

  // repeat counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rpt_q <= '0;
    else        rpt_q <= rpt_d;
  end

  assign rpt_pulse = rpt_hit;
`else
  assign rpt_pulse = 1'b0;
`endif

  assign io.swt       = swt_q;
  assign io.swt_chg   = chg_q;
  assign io.btn_level = (state_q == HELD) ||
                        (state_q == DEB_REL);
  assign io.btn_pulse = pulse_q;

endmodule

// File: tb/tb_aux_input_cond.sv
// tb_aux_input_cond: directed stimulus, queued expectations,
// monitor pops on every btn_pulse / swt_chg.
module tb_aux_input_cond;

  logic clk;
  logic rst_n;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    int          c;
    logic [15:0] v;
  } swt_exp_t;

  int       pq[$];
  swt_exp_t sq[$];

  aux_input_cond_if #(.SwtBits(16)) bus ();

  aux_input_cond #(
    .SwtBits    (16),
    .DebounceCnt(8),
    .RepeatCnt  (20)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %h want %h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask

  // monitor: every output event must match the queue head
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.btn_pulse) begin
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL pulse_extra at cyc %0d: got pulse want none",
                   cyc);
        end else begin
          int e;
          e = pq.pop_front();
          if (e != cyc) begin
            errors++;
            $display("FAIL pulse_time: got cyc %0d want cyc %0d",
                     cyc, e);
          end
        end
      end
      if (bus.swt_chg) begin
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL chg_extra at cyc %0d: got strobe want none",
                   cyc);
        end else begin
          swt_exp_t s;
          s = sq.pop_front();
          if (s.c != cyc || s.v !== bus.swt) begin
            errors++;
            $display("FAIL chg_event: got cyc %0d swt %h want cyc %0d swt %h",
                     cyc, bus.swt, s.c, s.v);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, f, g, p, q, r;
    rst_n       = 1'b0;
    bus.swt_raw = 16'hFFFF;
    bus.btn_raw = 1'b1;

    // reset holds every output low despite active inputs
    for (int i = 0; i < 6; i++) begin
      wait_n(1);
      chk("reset_outs",
          {bus.swt, bus.swt_chg, bus.btn_level, bus.btn_pulse},
          32'h0);
    end
    bus.swt_raw = 16'h0000;
    bus.btn_raw = 1'b0;
    wait_n(1);
    rst_n = 1'b1;
    wait_n(4);
    chk("post_reset_swt", bus.swt, 32'h0);
    chk("post_reset_lvl", bus.btn_level, 32'h0);

    // clean edge on bit3: swt at +10, strobe at +11
    n = cyc;
    bus.swt_raw = 16'h0008;
    sq.push_back('{n + 11, 16'h0008});
    wait_n(9);
    chk("swt_edge_early", bus.swt, 32'h0);
    wait_n(1);
    chk("swt_edge", bus.swt, 32'h0008);
    wait_n(10);

    // 5-cycle glitch on bit5 is rejected
    bus.swt_raw = 16'h0028;
    wait_n(5);
    bus.swt_raw = 16'h0008;
    wait_n(20);
    chk("swt_glitch", bus.swt, 32'h0008);

    // two bits in one cycle: a single strobe
    n = cyc;
    bus.swt_raw = 16'h000B;
    sq.push_back('{n + 11, 16'h000B});
    wait_n(15);
    chk("swt_multi", bus.swt, 32'h000B);

    // bits 8 and 9 one cycle apart: back-to-back strobes
    n = cyc;
    bus.swt_raw = 16'h010B;
    wait_n(1);
    bus.swt_raw = 16'h030B;
    sq.push_back('{n + 11, 16'h030B});
    sq.push_back('{n + 12, 16'h030B});
    wait_n(16);
    chk("swt_consec", bus.swt, 32'h030B);

    // bouncy press, final rise at f: one pulse at f+10
    bus.btn_raw = 1'b1; wait_n(2);
    bus.btn_raw = 1'b0; wait_n(2);
    bus.btn_raw = 1'b1; wait_n(2);
    bus.btn_raw = 1'b0; wait_n(2);
    bus.btn_raw = 1'b1;
    f = cyc;
    pq.push_back(f + 10);
`ifdef AUX_INPUT_COND_AUTOREPEAT_EN
    pq.push_back(f + 30);
`endif
    wait_n(9);
    chk("press_lvl_early", bus.btn_level, 32'h0);
    wait_n(1);
    chk("press_lvl", bus.btn_level, 32'h1);
    wait_n(20);

    // release with two 3-cycle low glitches, then clean
    g = cyc;
    bus.btn_raw = 1'b0; wait_n(3);
    bus.btn_raw = 1'b1; wait_n(5);
    bus.btn_raw = 1'b0; wait_n(3);
    bus.btn_raw = 1'b1; wait_n(5);
    bus.btn_raw = 1'b0;
    wait_n(9);
    chk("rel_lvl_early", bus.btn_level, 32'h1);
    wait_n(1);
    chk("rel_lvl", bus.btn_level, 32'h0);
    chk("rel_cyc", cyc, g + 26);
    wait_n(10);

    // long hold: repeats every 20 cycles only with the macro
    p = cyc;
    bus.btn_raw = 1'b1;
    pq.push_back(p + 10);
`ifdef AUX_INPUT_COND_AUTOREPEAT_EN
    for (int k = 1; k <= 5; k++) pq.push_back(p + 10 + 20 * k);
`endif
    wait_n(110);
    bus.btn_raw = 1'b0;
    wait_n(20);
    chk("hold_lvl_off", bus.btn_level, 32'h0);
    chk("queues_drained", pq.size() + sq.size(), 32'h0);

    // reset mid-press with button still held
    q = cyc;
    bus.btn_raw = 1'b1;
    wait_n(5);
    rst_n = 1'b0;
    wait_n(1);
    chk("midrst_outs",
        {bus.swt, bus.swt_chg, bus.btn_level, bus.btn_pulse},
        32'h0);
    wait_n(2);
    rst_n = 1'b1;
    r = cyc;
    pq.push_back(r + 10);
    sq.push_back('{r + 11, 16'h030B});
    wait_n(9);
    chk("midrst_lvl_early", bus.btn_level, 32'h0);
    wait_n(1);
    chk("midrst_lvl", bus.btn_level, 32'h1);
    wait_n(5);
    bus.btn_raw = 1'b0;
    wait_n(20);
    chk("midrst_swt", bus.swt, 32'h030B);

    chk("pulse_q_empty", pq.size(), 32'h0);
    chk("swt_q_empty", sq.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
